// File: rtl/keypad_matrix_scanner_if.sv
// Key event handshake between the keypad scanner (master) and its consumer (slave).
// key_release exists only when KEYPAD_RELEASE_EVT_EN is defined.
interface keypad_matrix_scanner_if #(
    parameter int KW = 4
);
    logic [KW-1:0] key_code;
    logic          key_valid;
    logic          key_ready;
`ifdef KEYPAD_RELEASE_EVT_EN
    logic          key_release;

    modport master (output key_code, key_valid, key_release, input key_ready);
    modport slave  (input key_code, key_valid, key_release, output key_ready);
`else
    modport master (output key_code, key_valid, input key_ready);
    modport slave  (input key_code, key_valid, output key_ready);
`endif
endinterface

// File: rtl/keypad_matrix_scanner.sv
// ROWS x COLS keypad scanner: column strobing, frame debounce, key events via valid/ready.
// Optional release events are enabled with `define KEYPAD_RELEASE_EVT_EN.
module keypad_matrix_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3,
    parameter int KW       = $clog2(ROWS*COLS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ROWS-1:0]        fila,
    output logic [COLS-1:0]        col,
    output logic [ROWS*COLS-1:0]   pressed_map,
    output logic                   multi,
    keypad_matrix_scanner_if.master evt
);
    localparam int N  = ROWS*COLS;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = $clog2(DEBOUNCE+1);

    logic [DW-1:0] r_dwell;
    logic [CW-1:0] r_colidx;
    logic [N-1:0]  r_raw, r_prev, r_pressed, r_pend;
    logic [SW-1:0] r_stable;
    logic [KW-1:0] r_code;
    logic          r_valid;

    logic          w_term, w_frame_end, w_upd, w_ack, w_hold, w_any;
    logic [N-1:0]  w_raw_nxt, w_set_p, w_clr, w_pend_nxt;
    logic [SW-1:0] w_stab_nxt;
    logic [KW-1:0] w_nxt_code;

    function automatic logic [KW-1:0] lowest(input logic [N-1:0] v);
        lowest = '0;
        for (int i = N-1; i >= 0; i--)
            if (v[i]) lowest = KW'(i);
    endfunction

    assign w_term      = (r_dwell == DW'(SCAN_DIV-1));
    assign w_frame_end = w_term && (r_colidx == CW'(COLS-1));

    // The frame compare uses raw with the last column's sample already merged in.
    always_comb begin
        w_raw_nxt = r_raw;
        for (int r = 0; r < ROWS; r++)
            w_raw_nxt[r*COLS + int'(r_colidx)] = fila[r];
    end

    assign w_stab_nxt = (w_raw_nxt == r_prev)
                      ? ((r_stable == SW'(DEBOUNCE)) ? r_stable : r_stable + SW'(1))
                      : SW'(1);
    assign w_upd   = w_frame_end && (w_stab_nxt == SW'(DEBOUNCE)) && (w_raw_nxt != r_pressed);
    assign w_set_p = w_upd ? (w_raw_nxt & ~r_pressed) : '0;

    assign w_ack  = r_valid && evt.key_ready;
    assign w_hold = r_valid && !evt.key_ready;
    assign w_clr  = w_ack ? (N'(1) << r_code) : '0;

`ifdef KEYPAD_RELEASE_EVT_EN
    logic [N-1:0] r_prel, w_prel_nxt, w_set_r;
    logic         r_rel, w_nxt_rel;

    assign w_set_r    = w_upd ? (r_pressed & ~w_raw_nxt) : '0;
    // Clear only the mask that the accepted event came from; a same-cycle set still wins.
    assign w_prel_nxt = (r_prel & ~(r_rel ? w_clr : '0)) | w_set_r;
    assign w_pend_nxt = (r_pend & ~(r_rel ? '0 : w_clr)) | w_set_p;
    assign w_any      = (|w_pend_nxt) || (|w_prel_nxt);
    assign evt.key_release = r_rel;

    always_comb begin
        w_nxt_code = r_code;
        w_nxt_rel  = r_rel;
        if (|w_pend_nxt) begin
            w_nxt_code = lowest(w_pend_nxt);
            w_nxt_rel  = 1'b0;
        end else if (|w_prel_nxt) begin
            w_nxt_code = lowest(w_prel_nxt);
            w_nxt_rel  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prel <= '0;
            r_rel  <= 1'b0;
        end else begin
            r_prel <= w_prel_nxt;
            if (!w_hold) r_rel <= w_nxt_rel;
        end
    end
`else
    assign w_pend_nxt = (r_pend & ~w_clr) | w_set_p;
    assign w_any      = |w_pend_nxt;

    always_comb begin
        w_nxt_code = r_code;
        if (|w_pend_nxt) w_nxt_code = lowest(w_pend_nxt);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell   <= '0;
            r_colidx  <= '0;
            r_raw     <= '0;
            r_prev    <= '0;
            r_pressed <= '0;
            r_stable  <= '0;
            r_pend    <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
        end else begin
            if (w_term) begin
                r_dwell  <= '0;
                r_colidx <= (r_colidx == CW'(COLS-1)) ? '0 : r_colidx + CW'(1);
                r_raw    <= w_raw_nxt;
            end else begin
                r_dwell  <= r_dwell + DW'(1);
            end
            if (w_frame_end) begin
                r_prev   <= w_raw_nxt;
                r_stable <= w_stab_nxt;
            end
            if (w_upd) r_pressed <= w_raw_nxt;
            r_pend  <= w_pend_nxt;
            r_valid <= w_any;
            // Code is frozen while an offered event waits for the consumer.
            if (!w_hold) r_code <= w_nxt_code;
        end
    end

    assign col           = COLS'(1) << r_colidx;
    assign pressed_map   = r_pressed;
    assign multi         = |(r_pressed & (r_pressed - N'(1)));
    assign evt.key_code  = r_code;
    assign evt.key_valid = r_valid;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner (4x4, SCAN_DIV=4, DEBOUNCE=3): vector table plus corner sequences.
module tb_keypad_matrix_scanner;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  fila, col;
    logic [15:0] pressed_map, keys;
    logic        multi;

    keypad_matrix_scanner_if #(.KW(4)) kif ();

    keypad_matrix_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk(clk), .rst_n(rst_n), .fila(fila), .col(col),
        .pressed_map(pressed_map), .multi(multi), .evt(kif)
    );

    always #5 clk = ~clk;

    // Switch matrix model: a row reads high when a pressed key sits on the driven column.
    always_comb
        for (int r = 0; r < 4; r++) fila[r] = |(keys[r*4 +: 4] & col);

    int total = 0, bad = 0;
    int cyc = 0, ev_cnt = 0, ev_t = 0;
    logic [3:0] ev_code = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && kif.key_valid && kif.key_ready) begin
            ev_cnt  <= ev_cnt + 1;
            ev_code <= kif.key_code;
            ev_t    <= cyc;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (kif.key_valid !== 1'b1 && n < lim) begin @(negedge clk); n++; end
    endtask

    task automatic wait_map0(input int lim);
        int n = 0;
        while (pressed_map !== 16'h0 && n < lim) begin @(negedge clk); n++; end
    endtask

    task automatic drain_release(input int nev, input logic [3:0] c0, input logic [3:0] c1);
`ifdef KEYPAD_RELEASE_EVT_EN
        for (int k = 0; k < nev; k++) begin
            chk("rel_valid", kif.key_valid, 1);
            chk("rel_flag", kif.key_release, 1);
            chk("rel_code", kif.key_code, (k == 0) ? c0 : c1);
            kif.key_ready = 1'b1; @(negedge clk); kif.key_ready = 1'b0;
        end
`endif
        chk("drained", kif.key_valid, 0);
    endtask

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  c0, c1;
        int          nev;
        logic [15:0] map;
        logic        mul;
    } vec_t;

    vec_t tbl[6];
    int   base, t0;

    initial begin
        tbl[0] = '{16'h0040,  4'd6,  4'd0, 1, 16'h0040, 1'b0};
        tbl[1] = '{16'h0001,  4'd0,  4'd0, 1, 16'h0001, 1'b0};
        tbl[2] = '{16'h8000, 4'd15,  4'd0, 1, 16'h8000, 1'b0};
        tbl[3] = '{16'h8001,  4'd0, 4'd15, 2, 16'h8001, 1'b1};
        tbl[4] = '{16'h0008,  4'd3,  4'd0, 1, 16'h0008, 1'b0};
        tbl[5] = '{16'h0600,  4'd9, 4'd10, 2, 16'h0600, 1'b1};

        rst_n = 1'b0; keys = '0; kif.key_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_col", col, 4'b0001);
        chk("rst_valid", kif.key_valid, 0);
        chk("rst_code", kif.key_code, 0);
        chk("rst_map", pressed_map, 0);
        chk("rst_multi", multi, 0);

        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk("col_seq", col, 4'b0001 << ((k / 4) % 4));
            @(negedge clk);
        end

        foreach (tbl[i]) begin
            keys = tbl[i].keys; kif.key_ready = 1'b0;
            wait_valid(66);
            chk("press_lat", kif.key_valid, 1);
            chk("code0", kif.key_code, tbl[i].c0);
            chk("map", pressed_map, tbl[i].map);
            chk("multi", multi, tbl[i].mul);
`ifdef KEYPAD_RELEASE_EVT_EN
            chk("press_flag", kif.key_release, 0);
`endif
            repeat (5) @(negedge clk);
            chk("hold_valid", kif.key_valid, 1);
            chk("hold_code", kif.key_code, tbl[i].c0);
            kif.key_ready = 1'b1; @(negedge clk);
            if (tbl[i].nev == 2) begin
                chk("next_valid", kif.key_valid, 1);
                chk("code1", kif.key_code, tbl[i].c1);
                @(negedge clk);
            end
            kif.key_ready = 1'b0;
            chk("after_accept", kif.key_valid, 0);
            keys = '0;
            wait_map0(80);
            chk("release_map", pressed_map, 0);
            drain_release(tbl[i].nev, tbl[i].c0, tbl[i].c1);
        end

        // Bounce on F2C3, aligned to a frame start.
        begin
            int n = 0;
            while (col !== 4'b1000 && n < 40) begin @(negedge clk); n++; end
            while (col !== 4'b0001 && n < 40) begin @(negedge clk); n++; end
            chk("align", col, 4'b0001);
        end
        base = ev_cnt; t0 = cyc; kif.key_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            repeat (10) @(negedge clk);
            keys[6] = ~keys[6];
        end
        keys[6] = 1'b1;
        repeat (80) @(negedge clk);
        chk("bounce_events", ev_cnt - base, 1);
        chk("bounce_code", ev_code, 6);
        chk("bounce_late", (ev_t - t0) >= 80, 1);
        chk("bounce_map", pressed_map, 16'h0040);
        kif.key_ready = 1'b0; keys = '0;
        wait_map0(80);
        drain_release(1, 4'd6, 4'd0);

        // Release before accept: F3C2 stays reported.
        keys[9] = 1'b1;
        wait_valid(66);
        chk("rba_code", kif.key_code, 9);
        keys = '0;
        wait_map0(80);
        chk("rba_map", pressed_map, 0);
        chk("rba_valid", kif.key_valid, 1);
        chk("rba_code_held", kif.key_code, 9);
        kif.key_ready = 1'b1; @(negedge clk); kif.key_ready = 1'b0;
        drain_release(1, 4'd9, 4'd0);

        // Reset mid-dwell with an unaccepted event outstanding.
        keys[6] = 1'b1;
        wait_valid(66);
        chk("pre_rst_valid", kif.key_valid, 1);
        keys = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_col", col, 4'b0001);
        chk("mid_rst_valid", kif.key_valid, 0);
        chk("mid_rst_map", pressed_map, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (70) @(negedge clk);
        chk("post_rst_valid", kif.key_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Parametrised successor to the team's 4x4 keypad scanner. Drives one-hot column strobes across a ROWS x COLS switch matrix and samples the row inputs once per column dwell. Debounces the full key map over whole scan frames and reports each new key press as a binary key code through a valid/ready handshake. Sits between the board keypad pins and the calculator/control FSM, replacing the free-running 4x4 one-hot decoder.

## Interface
Parameters:
- `ROWS`, default 4: number of matrix rows, range 2..8.
- `COLS`, default 4: number of matrix columns, range 2..8.
- `SCAN_DIV`, default 4: clock cycles each column is driven, minimum 2.
- `DEBOUNCE`, default 3: consecutive identical frames required before the debounced map updates, minimum 1.
- `KW`, default `$clog2(ROWS*COLS)`: key code width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: async active-low reset.
- `fila` in ROWS: row sense lines, active-high, synchronised externally.
- `col` out COLS: one-hot column drive, active-high.
- `key_code` out KW: index of the reported key, `row*COLS + col`; F1C1 = 0, F1C2 = 1, and so on.
- `key_valid` out 1: event available.
- `key_ready` in 1: consumer accepts the event.
- `pressed_map` out ROWS*COLS: debounced key map, bit index = key code.
- `multi` out 1: more than one bit set in `pressed_map`.

## Operation
- **Column counter:**
  - Counts 0..COLS-1.
  - `col` = `1 << colidx`.
  - The dwell counter counts 0..SCAN_DIV-1; on its terminal count, `colidx` advances and wraps from COLS-1 to 0.
- **Row sampling:**
  - On the terminal dwell cycle, `fila` is written into `raw[r*COLS+colidx]` for every r.
  - Sampling on the last cycle lets the lines settle.
- **Frame end** (terminal dwell with `colidx == COLS-1`):
  - If `raw` equals the previous frame's raw map, the stable counter increments, saturating at DEBOUNCE. Otherwise it is set to 1.
  - When the counter reaches DEBOUNCE and `raw != pressed_map`:
    - `pressed_map <= raw`.
    - `pending |= raw & ~pressed_map` (new presses only).
- **Event output:**
  - `key_valid` is high whenever `pending != 0`.
  - `key_code` is the lowest set index of `pending`, registered.
  - Handshake is `key_valid && key_ready`; it clears that bit of `pending`.
  - A release before acceptance does not cancel a pending event.
- **Simultaneous set and clear:** if a frame-end set and a handshake clear hit the same bit in the same cycle, set wins and the key is reported again.
- **multi** is combinational from `pressed_map`, e.g. `pressed_map & (pressed_map-1) != 0`.

## Timing
- **Reset values:** `col` = 1 (column 0), `key_code` = 0, `key_valid` = 0, `pressed_map` = 0, `multi` = 0, `pending` = 0, raw and previous maps = 0, all counters = 0.
- **Reset mid-scan:** takes effect immediately. No event survives reset.
- **Frame length:** F = COLS*SCAN_DIV cycles.
- **Press latency:**
  - A press held steady from the start of a frame updates `pressed_map` at the end of its DEBOUNCE-th frame.
  - `key_valid` rises on the next cycle.
  - Worst case is (DEBOUNCE+1)*F + 1 cycles.
- **Handshake rules:**
  - `key_valid` and `key_code` are held stable while `key_ready` is low.
  - After a handshake with further pending bits, the next code appears on the following cycle with no valid bubble.
- **Release latency:** the bit clears in `pressed_map` after the same DEBOUNCE frame rule.

## Configuration
- **`KEYPAD_RELEASE_EVT_EN` defined:**
  - Adds output `key_release` (1 bit) and a second pending mask, set by `pressed_map & ~raw` at debounce update.
  - Press events take priority over release events.
  - `key_release` = 1 identifies a release event and is held with `key_code`.
- **Undefined:**
  - Press events only.
  - The `key_release` port is absent.

## Test plan
Parameters for all scenarios: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3, F=16.

- **Reset:** assert `rst_n`=0 mid-dwell -> `col`=4'b0001, `key_valid`=0, `pressed_map`=0 immediately; after release, `col` steps 0001->0010->0100->1000 every 4 cycles and repeats.
- **Single press, accepted:** row 1 high only while `col`=0100, i.e. key F2C3, with `key_ready`=1 -> `pressed_map`=16'h0040, `key_code`=6, `key_valid` high for exactly 1 cycle, at most 65 cycles after press onset.
- **Bounce:** toggle the key every 10 cycles for 100 cycles, then hold -> no event until 3 identical frames; exactly one event, `key_code`=6.
- **Backpressure and multi:** press F1C1 and F4C4 together with `key_ready`=0 -> `key_valid` held with `key_code`=0, `multi`=1; raise `key_ready` for 2 cycles -> codes 0 then 15 on consecutive cycles, then `key_valid`=0.
- **Release before accept:** press F3C2, keep `key_ready`=0, release until `pressed_map`=0, then `key_ready`=1 -> one event, `key_code`=9.
- **Release events (`KEYPAD_RELEASE_EVT_EN`):** press then release F1C4 -> `key_code`=3 with `key_release`=0, later `key_code`=3 with `key_release`=1.
